// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master framer.
// Holds the FSM state encoding, SPI mode constants and a frame latency helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD,
        DONE
    } state_e;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    // Cycle index of the done pulse, counting the accepted start as cycle 0.
    function automatic int frame_latency(
        input int dw,
        input int sdw,
        input int hp,
        input bit gap_en
    );
        int lat;
        lat = 1 + hp * (2 * dw + 2);
        if (gap_en) begin
            lat = lat + 2 * hp * (dw / sdw - 1);
        end
        return lat;
    endfunction

endpackage

// File: rtl/spi_master_framer_if.sv
// Host and SPI-link signals of the SPI master framer.
// The master modport is the framer side; slave is the driver/monitor side.
interface spi_master_framer_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start,
        input  data_in,
        input  miso,
        output data_out,
        output busy,
        output done,
        output cs_n,
        output sclk,
        output mosi
    );

    modport slave (
        output start,
        output data_in,
        output miso,
        input  data_out,
        input  busy,
        input  done,
        input  cs_n,
        input  sclk,
        input  mosi
    );

endinterface

// File: rtl/spi_sclk_tick.sv
// Half-period timer for the SPI clock.
// Pulses tick_o on the last cycle of each half period; first_o marks its first.
module spi_sclk_tick #(
    parameter int SCLK_HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic first_o
);

    localparam int W = (SCLK_HALF_PERIOD > 1) ? $clog2(SCLK_HALF_PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(SCLK_HALF_PERIOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap;

    assign wrap    = (cnt_q == LAST);
    assign tick_o  = en_i && wrap;
    assign first_o = (cnt_q == '0);

    // Next count: hold when disabled, restart on clear or at the half-period end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_framer.sv
// Mode-0 SPI master moving one DATA_WIDTH word per chip-select frame.
// Define SPI_MASTER_BYTE_GAP_EN to idle sclk for 2 half periods between bytes.
module spi_master_framer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int SPI_DATA_WIDTH   = 8,
    parameter int SCLK_HALF_PERIOD = 4
) (
    input logic                 clk,
    input logic                 rst,
    spi_master_framer_if.master bus
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef SPI_MASTER_BYTE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  high_q, high_d;
    logic                  gap2_q, gap2_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;

    logic tick_en;
    logic tick;
    logic first;
    logic byte_end;

    assign tick_en = (state_q != IDLE) && (state_q != DONE);

    spi_sclk_tick #(
        .SCLK_HALF_PERIOD(SCLK_HALF_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tick_en),
        .clr_i  (!tick_en),
        .tick_o (tick),
        .first_o(first)
    );

    assign byte_end =
        ((32'(bit_q) + 32'd1) % 32'(SPI_DATA_WIDTH)) == 32'd0;

    // Frame sequencing, shift registers and registered pin values.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        bit_d   = bit_q;
        high_d  = high_q;
        gap2_d  = gap2_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    tx_d    = bus.data_in;
                    rx_d    = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                    gap2_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    sclk_d  = CPOL;
                    mosi_d  = bus.data_in[DATA_WIDTH-1];
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    high_d  = 1'b1;
                    sclk_d  = ~CPOL;
                end
            end
            SHIFT: begin
                if (high_q) begin
                    if (first) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], bus.miso};
                    end
                    if (tick) begin
                        high_d = 1'b0;
                        sclk_d = CPOL;
                        // The final bit stays on mosi through HOLD.
                        if (bit_q != LAST_BIT) begin
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[DATA_WIDTH-2];
                        end
                    end
                end else if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        if (GAP_EN && byte_end) begin
                            state_d = GAP;
                            gap2_d  = 1'b0;
                        end else begin
                            high_d = 1'b1;
                            sclk_d = ~CPOL;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap2_q) begin
                        state_d = SHIFT;
                        gap2_d  = 1'b0;
                        high_d  = 1'b1;
                        sclk_d  = ~CPOL;
                    end else begin
                        gap2_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    mosi_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = CPOL;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            bit_q   <= '0;
            high_q  <= 1'b0;
            gap2_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            gap2_q  <= gap2_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.data_out = dout_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_framer.sv
// Directed bench for spi_master_framer: vector table plus timing,
// ignored-start, mid-frame reset and small-parameter sequences.
module tb_spi_master_framer;

`ifdef SPI_MASTER_BYTE_GAP_EN
    localparam int LAT   = 289;
    localparam int LAT16 = 37;
    localparam int NLONG = 3;
`else
    localparam int LAT   = 265;
    localparam int LAT16 = 35;
    localparam int NLONG = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   mmode;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_framer_if #(.DATA_WIDTH(32)) bus ();
    spi_master_framer_if #(.DATA_WIDTH(16)) bus16 ();

    assign bus.miso   = (mmode == 0) ? bus.mosi : (mmode == 1);
    assign bus16.miso = bus16.mosi;

    spi_master_framer #(
        .DATA_WIDTH      (32),
        .SPI_DATA_WIDTH  (8),
        .SCLK_HALF_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    spi_master_framer #(
        .DATA_WIDTH      (16),
        .SPI_DATA_WIDTH  (8),
        .SCLK_HALF_PERIOD(1)
    ) dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16.master)
    );

    typedef struct {
        logic [31:0] din;
        int          mm;
        logic [31:0] exp_out;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    // One frame; the slave model logs mosi on every sclk rise.
    task automatic run_frame(
        input  logic [31:0] d,
        output int          dcyc,
        output logic [31:0] dout,
        output int          rises,
        output logic [31:0] cap,
        output int          busy_bad,
        output int          nlong,
        output logic        busy_after
    );
        logic ps;
        int   lowlen;
        bit   seen;
        dcyc = -1; dout = '0; rises = 0; cap = '0;
        busy_bad = 0; nlong = 0; busy_after = 1'b1;
        ps = 1'b0; lowlen = 0; seen = 1'b0;
        @(posedge clk); #1;
        bus.data_in = d;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.data_in = ~d;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (!bus.cs_n && !ps && bus.sclk) begin
                rises++;
                cap = {cap[30:0], bus.mosi};
                if (seen && lowlen == 12) nlong++;
                lowlen = 0;
                seen = 1'b1;
            end else if (seen && !bus.sclk) begin
                lowlen++;
            end
            ps = bus.sclk;
            if (!bus.busy) busy_bad++;
            if (bus.done) begin
                dcyc = k;
                dout = bus.data_out;
                @(negedge clk);
                busy_after = bus.busy;
                break;
            end
        end
    endtask

    initial begin
        vec_t        v[6];
        int          dcyc, rises, busy_bad, nlong, ndone;
        int          first_k, second_k;
        logic [31:0] dout, cap, dfirst;
        logic        busy_after, cs_at_done, busy_gap, cs_after, saw_done;
        logic [31:0] d1, dx, d3;

        v[0] = '{32'hA5C30F81, 0, 32'hA5C30F81};
        v[1] = '{32'hDEADBEEF, 0, 32'hDEADBEEF};
        v[2] = '{32'hDEADBEEF, 1, 32'hFFFFFFFF};
        v[3] = '{32'hDEADBEEF, 2, 32'h00000000};
        v[4] = '{32'h01020304, 0, 32'h01020304};
        v[5] = '{32'h80000001, 0, 32'h80000001};

        mmode = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        bus16.start = 1'b0;
        bus16.data_in = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
        chk("rst_sclk", 32'(bus.sclk), 32'd0);
        chk("rst_mosi", 32'(bus.mosi), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst16_cs_n", 32'(bus16.cs_n), 32'd1);
        chk("rst16_busy", 32'(bus16.busy), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mmode = v[i].mm;
            run_frame(v[i].din, dcyc, dout, rises, cap, busy_bad, nlong,
                      busy_after);
            chk("done_cycle", 32'(dcyc), 32'(LAT));
            chk("data_out", dout, v[i].exp_out);
            chk("sclk_rises", 32'(rises), 32'd32);
            chk("mosi_bytes", cap, v[i].din);
            chk("busy_hole", 32'(busy_bad), 32'd0);
            chk("busy_after", 32'(busy_after), 32'd0);
            chk("byte_gaps", 32'(nlong), 32'(NLONG));
        end

        // Starts at cycles 5 and LAT are dropped; LAT+1 opens frame two.
        mmode = 0;
        d1 = 32'h13579BDF;
        dx = 32'hFFFF0000;
        d3 = 32'h2468ACE0;
        ndone = 0; first_k = -1; second_k = -1; dfirst = '0;
        cs_at_done = 1'b0; busy_gap = 1'b1; cs_after = 1'b1;
        @(posedge clk); #1;
        bus.data_in = d1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = dx;
        for (int k = 1; k <= 2 * LAT + 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first_k < 0) begin
                    first_k = k;
                    dfirst = bus.data_out;
                end else begin
                    second_k = k;
                end
            end
            if (k == LAT) cs_at_done = bus.cs_n;
            if (k == LAT + 1) busy_gap = bus.busy;
            if (k == LAT + 2) cs_after = bus.cs_n;
            bus.start = (k == 5) || (k == LAT) || (k == LAT + 1);
            bus.data_in = (k == LAT + 1) ? d3 : dx;
        end
        bus.start = 1'b0;
        chk("b2b_ndone", 32'(ndone), 32'd2);
        chk("b2b_first", 32'(first_k), 32'(LAT));
        chk("b2b_first_data", dfirst, d1);
        chk("b2b_second", 32'(second_k), 32'(2 * LAT + 1));
        chk("b2b_second_data", bus.data_out, d3);
        chk("b2b_cs_done", 32'(cs_at_done), 32'd1);
        chk("b2b_busy_idle", 32'(busy_gap), 32'd0);
        chk("b2b_cs_next", 32'(cs_after), 32'd0);

        // Reset in the middle of a frame.
        saw_done = 1'b0;
        @(posedge clk); #1;
        bus.data_in = 32'hCAFEF00D;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 99) chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        end
        rst = 1'b0;
        #1;
        chk("mid_cs_n", 32'(bus.cs_n), 32'd1);
        chk("mid_sclk", 32'(bus.sclk), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_data_out", bus.data_out, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("mid_no_done", 32'(saw_done), 32'd0);
        run_frame(32'h0F1E2D3C, dcyc, dout, rises, cap, busy_bad, nlong,
                  busy_after);
        chk("post_rst_cycle", 32'(dcyc), 32'(LAT));
        chk("post_rst_data", dout, 32'h0F1E2D3C);

        // HP=1, 16-bit instance.
        dcyc = -1;
        dout = '0;
        @(posedge clk); #1;
        bus16.data_in = 16'h1234;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.data_in = 16'hFFFF;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus16.done) begin
                dcyc = k;
                dout = 32'(bus16.data_out);
                break;
            end
        end
        chk("small_done_cycle", 32'(dcyc), 32'(LAT16));
        chk("small_data_out", dout, 32'h00001234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
